// File: rtl/instruction_sequencer_pkg.sv
// Shared tiny-CPU definitions: opcode map, sequencer state encodings, helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package instruction_sequencer_pkg;

  // Opcode map, shared with the instruction decoder
  localparam logic [3:0] OP_CLR     = 4'b0000;
  localparam logic [3:0] OP_LDA     = 4'b0001;
  localparam logic [3:0] OP_LDB0    = 4'b0010;
  localparam logic [3:0] OP_LDB1    = 4'b0011;
  localparam logic [3:0] OP_ALU_ADD = 4'b0100;
  localparam logic [3:0] OP_ALU_SUB = 4'b0101;
  localparam logic [3:0] OP_ALU_AND = 4'b0110;
  localparam logic [3:0] OP_ALU_OR  = 4'b0111;
  localparam logic [3:0] OP_ALU_XOR = 4'b1000;
  localparam logic [3:0] OP_ALU_NOT = 4'b1001;
  localparam logic [3:0] OP_ALU_SHL = 4'b1010;
  localparam logic [3:0] OP_ALU_SHR = 4'b1011;
  localparam logic [3:0] OP_NOP     = 4'b1100;
  localparam logic [3:0] OP_HALT    = 4'b1111;

  // Sequencer state encodings
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;

  // True when the fetched word terminates the program rather than being issued
  function automatic logic is_terminator(input logic [3:0] op, input logic [3:0] halt_op);
    return (op == halt_op);
  endfunction

endpackage

// File: rtl/instruction_sequencer_prog_mem.sv
// Program store: PROG_DEPTH x 4-bit register file, synchronous write, combinational read.
// Latency: write visible on the read port the cycle after the write edge; read is same-cycle.
// Backpressure: none; writes are accepted whenever we=1 (gating is done by the caller).
module prog_mem #(
  parameter int         PROG_DEPTH = 16,
  parameter logic [3:0] RESET_VAL  = 4'b1111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [3:0] wdata,
  input  logic [3:0] raddr,
  output logic [3:0] rdata
);

  logic [3:0] mem [PROG_DEPTH];

  // Reset fills every word with RESET_VAL so an unprogrammed store halts at once
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PROG_DEPTH; i++) begin
        mem[i] <= RESET_VAL;
      end
    end else if (we && (int'(waddr) < PROG_DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  // Addresses past the configured depth read as RESET_VAL (terminator)
  always_comb begin
    rdata = RESET_VAL;
    if (int'(raddr) < PROG_DEPTH) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Fetches opcodes from the program store and issues them one per advance to the decoder.
// Latency: start in cycle N puts mem[0] on instruction (instr_valid=1) in cycle N+2.
// Backpressure: step_mode/step throttle issue; without an advance the output is NOP.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int         PROG_DEPTH  = 16,
  parameter logic [3:0] NOP_OPCODE  = OP_NOP,
  parameter logic [3:0] HALT_OPCODE = OP_HALT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [3:0] prog_data,
  input  logic       start,
  input  logic       step_mode,
  input  logic       step,
  output logic [3:0] instruction,
  output logic       instr_valid,
  output logic [3:0] pc,
  output logic       busy,
  output logic       halted
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] pc_nxt;
  logic [3:0] fetch_op;
  logic       mem_we;
  logic       advance;
  logic       issue;

  // Program edits are locked out while running so a live program cannot be patched
  assign mem_we = prog_we && (state != ST_RUN);

  prog_mem #(
    .PROG_DEPTH (PROG_DEPTH),
    .RESET_VAL  (HALT_OPCODE)
  ) u_prog_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (fetch_op)
  );

  // step_mode is used combinationally so a mode change applies on the same cycle
  always_comb begin
    advance = (state == ST_RUN) && (!step_mode || step);
    issue   = advance && !is_terminator(fetch_op, HALT_OPCODE);
  end

  // Next-state and next-pc selection
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_nxt = ST_RUN;
          pc_nxt    = 4'd0;
        end
      end
      ST_RUN: begin
        if (advance) begin
          if (issue) begin
            pc_nxt = pc + 4'd1;   // 4-bit add wraps 15 -> 0
          end else begin
            state_nxt = ST_HALTED; // pc holds on the terminator address
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        pc_nxt    = 4'd0;
      end
    endcase
  end

  // State, pc and issue registers; reset wins over every other input
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= 4'd0;
      instruction <= NOP_OPCODE;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instruction <= issue ? fetch_op : NOP_OPCODE;
      instr_valid <= issue;
    end
  end

  assign busy   = (state == ST_RUN);
  assign halted = (state == ST_HALTED);

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = 4'd0;
  logic [3:0] prog_data = 4'd0;
  logic       start = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic [3:0] instruction;
  logic       instr_valid;
  logic [3:0] pc;
  logic       busy;
  logic       halted;

  int errors = 0;
  int checks = 0;

  logic [3:0] wrap_prog [16];
  logic [3:0] step_ops [3];

  instruction_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .step_mode   (step_mode),
    .step        (step),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_instr, input logic e_vld,
                         input logic [3:0] e_pc, input logic e_busy, input logic e_halted);
    chk({tag, ".instruction"}, {28'd0, instruction}, {28'd0, e_instr});
    chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, e_vld});
    chk({tag, ".pc"},          {28'd0, pc},          {28'd0, e_pc});
    chk({tag, ".busy"},        {31'd0, busy},        {31'd0, e_busy});
    chk({tag, ".halted"},      {31'd0, halted},      {31'd0, e_halted});
  endtask

  task automatic write_word(input logic [3:0] a, input logic [3:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  initial begin
    step_ops[0] = 4'b0001; step_ops[1] = 4'b0010; step_ops[2] = 4'b0100;
    for (int i = 0; i < 15; i++) wrap_prog[i] = 4'(i);
    wrap_prog[15] = 4'b0101;

    // Reset state
    #1;
    tick(); tick();
    chk_out("reset", 4'b1100, 1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_out("idle", 4'b1100, 1'b0, 4'd0, 1'b0, 1'b0);

    // Free-running program 0001,0010,0100,HALT
    write_word(4'd0, 4'b0001);
    write_word(4'd1, 4'b0010);
    write_word(4'd2, 4'b0100);
    write_word(4'd3, 4'b1111);
    start = 1'b1; tick(); start = 1'b0;
    chk_out("run.n1", 4'b1100, 1'b0, 4'd0, 1'b1, 1'b0);
    tick(); chk_out("run.n2", 4'b0001, 1'b1, 4'd1, 1'b1, 1'b0);
    tick(); chk_out("run.n3", 4'b0010, 1'b1, 4'd2, 1'b1, 1'b0);
    tick(); chk_out("run.n4", 4'b0100, 1'b1, 4'd3, 1'b1, 1'b0);
    tick(); chk_out("run.halt", 4'b1100, 1'b0, 4'd3, 1'b0, 1'b1);
    tick(); chk_out("run.hold", 4'b1100, 1'b0, 4'd3, 1'b0, 1'b1);

    // Single-step: one issue per pulse, pulses 3 cycles apart
    step_mode = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk_out("step.start", 4'b1100, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; tick(); step = 1'b0;
      chk_out("step.pulse", step_ops[k], 1'b1, 4'(k + 1), 1'b1, 1'b0);
      tick(); chk_out("step.gap1", 4'b1100, 1'b0, 4'(k + 1), 1'b1, 1'b0);
      tick(); chk_out("step.gap2", 4'b1100, 1'b0, 4'(k + 1), 1'b1, 1'b0);
    end
    step = 1'b1; tick(); step = 1'b0;
    chk_out("step.halt", 4'b1100, 1'b0, 4'd3, 1'b0, 1'b1);
    step = 1'b1; tick(); step = 1'b0;
    chk_out("step.ignored", 4'b1100, 1'b0, 4'd3, 1'b0, 1'b1);
    step_mode = 1'b0;

    // Wrap: 16 words, no terminator
    for (int i = 0; i < 16; i++) write_word(4'(i), wrap_prog[i]);
    start = 1'b1; tick(); start = 1'b0;
    chk_out("wrap.start", 4'b1100, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int k = 0; k < 17; k++) begin
      tick();
      chk_out("wrap.issue", wrap_prog[k % 16], 1'b1, 4'((k + 1) % 16), 1'b1, 1'b0);
    end
    // Write and re-start during RUN are both ignored
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 4'b1010; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    chk_out("run.restart", wrap_prog[1], 1'b1, 4'd2, 1'b1, 1'b0);
    for (int k = 18; k < 33; k++) begin
      tick();
      chk_out("run.nowrite", wrap_prog[k % 16], 1'b1, 4'((k + 1) % 16), 1'b1, 1'b0);
    end

    // Step_mode raised mid-run freezes issue on the same cycle
    step_mode = 1'b1; tick();
    chk_out("mode.freeze", 4'b1100, 1'b0, 4'd1, 1'b1, 1'b0);
    step_mode = 1'b0; tick();
    chk_out("mode.resume", wrap_prog[1], 1'b1, 4'd2, 1'b1, 1'b0);

    // Reset mid-run overrides start/prog_we/step; memory returns to all-HALT
    reset = 1'b1; start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = 4'b0011; step = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; prog_we = 1'b0; step = 1'b0;
    chk_out("abort", 4'b1100, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(); chk_out("abort.idle", 4'b1100, 1'b0, 4'd0, 1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk_out("empty.start", 4'b1100, 1'b0, 4'd0, 1'b1, 1'b0);
    tick(); chk_out("empty.halt", 4'b1100, 1'b0, 4'd0, 1'b0, 1'b1);

    // Write and start in the same cycle: the run sees the new word
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 4'b0000; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    chk_out("wrst.start", 4'b1100, 1'b0, 4'd0, 1'b1, 1'b0);
    tick(); chk_out("wrst.issue", 4'b0000, 1'b1, 4'd1, 1'b1, 1'b0);
    tick(); chk_out("wrst.halt", 4'b1100, 1'b0, 4'd1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 The parameter PROG_DEPTH SHALL default to 16 and sets the number of 4-bit program words.
REQ-002 The parameter NOP_OPCODE SHALL default to 4'b1100 and is the idle instruction; it asserts no decoder enables.
REQ-003 The parameter HALT_OPCODE SHALL default to 4'b1111 and is the program terminator; it is never issued.
REQ-004 Port clk SHALL be an input, width 1: the single clock; all logic updates on its rising edge.
REQ-005 Port reset SHALL be an input, width 1: synchronous, active-high reset.
REQ-006 Port prog_we SHALL be an input, width 1: program memory write strobe.
REQ-007 Port prog_addr SHALL be an input, width 4: program memory write address.
REQ-008 Port prog_data SHALL be an input, width 4: opcode to write.
REQ-009 Port start SHALL be an input, width 1: single-cycle pulse that begins execution at address 0.
REQ-010 Port step_mode SHALL be an input, width 1: 1 selects single-step execution.
REQ-011 Port step SHALL be an input, width 1: advances one instruction while step_mode=1.
REQ-012 Port instruction SHALL be an output, width 4: registered opcode driven to the instruction decoder.
REQ-013 Port instr_valid SHALL be an output, width 1: 1 in cycles where instruction carries an issued program word.
REQ-014 Port pc SHALL be an output, width 4: current program counter.
REQ-015 Port busy SHALL be an output, width 1: 1 while in RUN.
REQ-016 Port halted SHALL be an output, width 1: 1 while in HALTED.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and HALTED.
REQ-018 In IDLE or HALTED, start=1 SHALL set pc=0 and move to RUN on the next edge.
REQ-019 In RUN, an advance SHALL occur on every cycle when step_mode=0, and only on cycles with step=1 when step_mode=1.
REQ-020 On an advance with mem[pc] not equal to HALT_OPCODE, the block SHALL register instruction=mem[pc] and instr_valid=1 (visible the next cycle) and set pc to pc+1 modulo 16.
REQ-021 On an advance with mem[pc]=HALT_OPCODE, the block SHALL enter HALTED, hold pc, and drive instr_valid=0.
REQ-022 Latency: start in cycle N SHALL put mem[0] on instruction with instr_valid=1 in cycle N+2 when step_mode=0.
REQ-023 In any cycle without an advance, instruction SHALL equal NOP_OPCODE and instr_valid SHALL be 0.
REQ-024 pc SHALL wrap from 15 to 0 and execution SHALL continue.
REQ-025 start SHALL be ignored while in RUN.
REQ-026 prog_we SHALL write mem[prog_addr]=prog_data only in IDLE or HALTED, and SHALL be ignored in RUN.
REQ-027 When prog_we and start occur in the same cycle, the write SHALL complete and execution SHALL observe the new value.
REQ-028 step SHALL be ignored when step_mode=0 or outside RUN.
REQ-029 A change of step_mode mid-run SHALL take effect on the same cycle.

Reset
REQ-030 While reset=1, the block SHALL set state=IDLE, pc=0, instruction=NOP_OPCODE, instr_valid=0, busy=0, halted=0, and all memory words to HALT_OPCODE.
REQ-031 reset SHALL override start, prog_we and step in the same cycle.
REQ-032 A reset during RUN SHALL abort execution with no further instr_valid pulse.

Structure
REQ-033 The opcode constants (CLR=0000, LDA=0001, LDB0=0010, LDB1=0011, ALU ops 0100-1011, NOP, HALT) and the state encodings SHALL reside in the shared tiny-CPU package/include, shared with the instruction decoder.
REQ-034 The program storage SHALL be a sub-module prog_mem (16x4 register file, synchronous write, combinational read).

Verification
REQ-035 Load 0001,0010,0100,1111; start, step_mode=0 -> instruction 0001,0010,0100 with instr_valid=1 in cycles N+2..N+4, then halted=1 with pc=3.
REQ-036 The same program with step_mode=1 and step pulses 3 cycles apart -> exactly one valid instruction per pulse; otherwise instruction=1100.
REQ-037 Load 16 words with no HALT_OPCODE -> pc wraps 15->0 and the 17th issued instruction equals mem[0].
REQ-038 prog_we to address 0 during RUN -> memory unchanged; a repeated start during RUN -> pc unaffected.
REQ-039 reset asserted mid-run -> next cycle instr_valid=0, instruction=1100, busy=0; a subsequent start issues nothing and halts immediately (memory is all HALT).
REQ-040 prog_we and start in the same cycle writing 0000 to address 0 -> first issued instruction is 0000.
